// File: rtl/uart_byte_receiver_if.sv
// Byte-side bundle of the UART receiver: raw line in, qualified bytes and
// status out. The receiver takes the slave view; whoever drives the line
// and consumes bytes takes the master view.
interface uart_byte_receiver_if;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_error;
    logic       busy;

    modport slave  (input rx, output rx_data, rx_valid, frame_error, busy);
    modport master (output rx, input rx_data, rx_valid, frame_error, busy);
endinterface

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver with 16x oversampling and 2-of-3 majority voting around
// mid-bit. Good bytes come out with a one-cycle rx_valid strobe; a low stop
// bit gives one frame_error strobe and the line must return high before the
// next start bit is looked for.
module uart_byte_receiver #(
    parameter int BAUD_DIV = 27
) (
    input  logic                clk,
    input  logic                reset_n,
    uart_byte_receiver_if.slave u
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    localparam logic [15:0] DIV_MAX = 16'(BAUD_DIV - 1);

    state_t      state;
    logic        rx_m, rx_s;
    logic [15:0] div;
    logic [3:0]  sc;        // ticks already seen in this bit, mod 16
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic        v0, v1;    // votes captured on ticks 7 and 8
    logic [7:0]  rx_data_q;
    logic        rx_valid_q;
    logic        frame_error_q;

    logic        tick;
    logic        decide;
    logic        maj;

    // The tick that is firing now is number sc+1 of the bit, so sc==8 marks
    // tick 9 and the third vote is the live synchronized line.
    assign tick   = (div == DIV_MAX);
    assign decide = tick && (sc == 4'd8);
    assign maj    = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

    assign u.rx_data     = rx_data_q;
    assign u.rx_valid    = rx_valid_q;
    assign u.frame_error = frame_error_q;
    assign u.busy        = (state != IDLE);

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= u.rx;
            rx_s <= rx_m;
        end
    end

    // Frame FSM with tick divider, sample counter, voting and output strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            div           <= '0;
            sc            <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            v0            <= 1'b1;
            v1            <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            frame_error_q <= 1'b0;

            // Timebase only runs while a frame is being sampled, so tick k
            // always lands k*BAUD_DIV clocks after the start edge was seen.
            if (state == IDLE || state == BRK) begin
                div <= '0;
                sc  <= '0;
            end else begin
                div <= tick ? '0 : div + 16'd1;
                if (tick)                  sc <= sc + 4'd1;
                if (tick && sc == 4'd6)    v0 <= rx_s;
                if (tick && sc == 4'd7)    v1 <= rx_s;
            end

            case (state)
                IDLE: begin
                    bit_idx <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    // A start bit that votes high was a glitch: drop it silently.
                    if (decide) state <= maj ? IDLE : DATA;
                end
                DATA: begin
                    if (decide) begin
                        shreg   <= {maj, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so a back-to-back start edge is caught.
                    if (decide) begin
                        if (maj) begin
                            rx_data_q  <= shreg;
                            rx_valid_q <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            frame_error_q <= 1'b1;
                            state         <= BRK;
                        end
                    end
                end
                BRK: begin
                    // Held-low line: one error only, wait for the line to recover.
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_byte_receiver.md
# uart_byte_receiver

Asynchronous-serial receiver that turns the raw UART RX pin into validated 8-bit bytes, one per frame, for the UART command accumulator directly downstream. It synchronizes the line, detects and qualifies start bits, and majority-votes each bit at 16x oversampling. Each good byte is presented with a one-cycle strobe that drives the accumulator's `input_data` / `accumulate` pair. Framing errors are flagged and never forwarded.

## Interface
- `BAUD_DIV`, default 27: clocks per oversample tick; bit time = 16*BAUD_DIV clocks (50 MHz / (115200*16) ≈ 27). Legal range 2–65535.
- `clk` input 1: system clock, rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `rx` input 1: raw serial line, idle high, asynchronous to `clk`.
- `rx_data` output 8: last good byte; feeds accumulator `input_data`.
- `rx_valid` output 1: one-cycle pulse per good byte; feeds accumulator `accumulate`.
- `frame_error` output 1: one-cycle pulse when the stop bit samples low.
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- Frame format: 8N1. One start bit (0), 8 data bits LSB first, one stop bit (1).
- Synchronizer: two flops on `rx`. Both flops reset to 1. All logic uses the second flop output (`rx_s`).
- Tick divider: counter held at 0 in IDLE. Counts 0..BAUD_DIV-1 otherwise. A tick fires on wrap.
- Sample counter: 4 bits, counts ticks 1..16 within each bit period, then wraps.
- Bit decision: `rx_s` is captured on ticks 7, 8 and 9 of the bit. The bit value is the 2-of-3 majority. The decision is made on tick 9.
- States:
  - IDLE: `rx_s`==0 → START. Divider and sample counter cleared.
  - START: decision at tick 9. If 0 → DATA with bit index 0. If 1 (false start/glitch) → IDLE, no output.
  - DATA: at each decision, shift the bit into the shift register at the MSB and shift right, so the LSB arrives first. Increment bit index. After index 7 → STOP.
  - STOP: decision at tick 9.
    - If 1: load `rx_data` with the shift register, pulse `rx_valid`, → IDLE. The remaining half stop bit is ignored, so back-to-back frames are accepted.
    - If 0: pulse `frame_error`, leave `rx_data` unchanged, → BREAK.
  - BREAK: wait until `rx_s`==1, then → IDLE. A held-low line (break) produces exactly one `frame_error`.
- `rx_data` and `rx_valid` are updated on the same clock edge. `rx_data` holds until the next good frame, so it is stable while `accumulate` is high and afterwards.
- `rx_valid` and `frame_error` are never high in the same cycle.
- Reset (any time, including mid-frame): state = IDLE and all counters cleared. Outputs `rx_data`=0x00, `rx_valid`=0, `frame_error`=0, `busy`=0. Synchronizer flops = 1.

## Timing
- Let T be the clock edge at which IDLE sees `rx_s`==0. This is 2–3 clocks after the `rx` falling edge.
- Absolute tick k occurs at edge T + k*BAUD_DIV.
- Decision ticks:
  - Start bit: tick 9.
  - Data bit n (n = 0..7): tick 16(n+1)+9.
  - Stop bit: tick 153.
- `rx_valid` or `frame_error` is high for the single cycle following edge T+153*BAUD_DIV.
- `busy` rises in the cycle after T. It falls in the same cycle the `rx_valid` pulse is high.
- Throughput: one byte per 10 bit times sustained. A new start edge is accepted one clock after the return to IDLE.
- Tolerance: sampling at 7/16–9/16 of each bit gives roughly ±3% baud mismatch over the frame.

## Test plan
- Reset: hold `reset_n`=0 with `rx` toggling. Required: `rx_data`=0x00, `rx_valid`=0, `frame_error`=0, `busy`=0. After release with `rx`=1, outputs stay quiet.
- Single byte, BAUD_DIV=4 (64 clocks/bit): send 0xA5. Required: exactly one `rx_valid` pulse at T+612(+1), `rx_data`=0xA5 on that cycle and held afterwards, `frame_error` never high.
- Back-to-back frames: send 0xBE, 0xEF, 0x0D with no idle gap. Required: three `rx_valid` pulses 640 clocks apart, carrying 0xBE, 0xEF, 0x0D in order.
- Glitch rejection: drive `rx` low for 16 clocks (a quarter bit), then high. Required: no `rx_valid`, no `frame_error`, and `busy` returns to 0 at START decision plus 1 clock. A following 0x55 is received correctly.
- Framing error and break: after a good 0x3C, send 0x81 with a low stop bit and hold `rx` low for 1000 clocks. Required: one `frame_error` pulse, no `rx_valid`, `rx_data` stays 0x3C, and `busy` stays high until `rx` returns high. A following 0x42 is received correctly.
- Reset mid-frame: assert `reset_n` low during data bit 4 of 0xFF. Required: outputs go to reset values immediately, with no pulse. After release, a clean 0x12 is received with the correct value and timing.
